// File: rtl/led_scan_ctrl.sv
// Multi-digit 7-segment scan controller on the CPU IO bus.
// Shows user-written hex digits or a frame-synchronised sort/cycle-count snapshot.
module led_scan_ctrl #(
  parameter int          DIGIT_NUM     = 8,
  parameter logic [27:0] SCAN_COUNT    = 28'h3000,
  parameter int          BLANK_CYCLES  = 16,
  parameter bit          ACTIVE_LOW    = 1'b1,
  parameter logic [4:0]  LED_BASE_ADDR = 5'h8,
  parameter logic [4:0]  LED_CTRL_ADDR = 5'h3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wrEnable,
  input  logic [4:0]           wrAddr,
  input  logic [15:0]          wrData,
  input  logic [31:0]          sortCount,
  input  logic [31:0]          cycleCount,
  output logic [7:0]           segOut,
  output logic [DIGIT_NUM-1:0] gateOut,
  output logic                 ledMode,
  output logic                 frameDone
);

  localparam int                IDXW      = $clog2(DIGIT_NUM);
  localparam int                HALF_W    = DIGIT_NUM * 2;
  localparam int                SHADOW_W  = DIGIT_NUM * 4;
  localparam logic [27:0]       CNT_LAST  = SCAN_COUNT - 28'd1;
  localparam logic [27:0]       BLANK_CNT = 28'(BLANK_CYCLES);
  localparam logic [IDXW-1:0]   IDX_LAST  = IDXW'(DIGIT_NUM - 1);
  localparam logic [5:0]        NUM6      = 6'(DIGIT_NUM);

  logic [27:0]          r_cnt;
  logic [IDXW-1:0]      r_idx;
  logic [3:0]           r_user_digit [DIGIT_NUM];
  logic [DIGIT_NUM-1:0] r_dp;
  logic                 r_mode_req;
  logic                 r_mode;
  logic [SHADOW_W-1:0]  r_shadow;
  logic                 r_frame_done;
  logic [7:0]           r_seg;
  logic [DIGIT_NUM-1:0] r_gate;

  logic                 w_cnt_wrap;
  logic                 w_boundary;
  logic [5:0]           w_off;
  logic                 w_digit_wr;
  logic                 w_ctrl_wr;
  logic                 w_mode_req_nxt;
  logic [3:0]           w_nibble;
  logic                 w_dp;
  logic [6:0]           w_seg_raw;
  logic [DIGIT_NUM-1:0] w_onehot;
  logic [DIGIT_NUM-1:0] w_gate_nxt;
  logic [7:0]           w_seg_nxt;

  assign w_cnt_wrap = (r_cnt == CNT_LAST);
  assign w_boundary = w_cnt_wrap && (r_idx == IDX_LAST);

  // Six-bit offset keeps addresses below the base from aliasing onto digits.
  assign w_off      = {1'b0, wrAddr} - {1'b0, LED_BASE_ADDR};
  assign w_digit_wr = wrEnable && (wrAddr >= LED_BASE_ADDR) && (w_off < NUM6);
  assign w_ctrl_wr  = wrEnable && (wrAddr == LED_CTRL_ADDR);

  // A mode write on the boundary edge is applied on that same edge.
  assign w_mode_req_nxt = w_ctrl_wr ? wrData[0] : r_mode_req;

  always_comb begin
    w_nibble = r_shadow[{r_idx, 2'b00} +: 4];
    w_dp     = 1'b0;
    if (r_mode) begin
      w_nibble = r_user_digit[r_idx];
      w_dp     = r_dp[r_idx];
    end
  end

  always_comb begin
    w_seg_raw = 7'h00;
    case (w_nibble)
      4'h0: w_seg_raw = 7'h3F;
      4'h1: w_seg_raw = 7'h06;
      4'h2: w_seg_raw = 7'h5B;
      4'h3: w_seg_raw = 7'h4F;
      4'h4: w_seg_raw = 7'h66;
      4'h5: w_seg_raw = 7'h6D;
      4'h6: w_seg_raw = 7'h7D;
      4'h7: w_seg_raw = 7'h07;
      4'h8: w_seg_raw = 7'h7F;
      4'h9: w_seg_raw = 7'h6F;
      4'hA: w_seg_raw = 7'h77;
      4'hB: w_seg_raw = 7'h7C;
      4'hC: w_seg_raw = 7'h39;
      4'hD: w_seg_raw = 7'h5E;
      4'hE: w_seg_raw = 7'h79;
      4'hF: w_seg_raw = 7'h71;
      default: w_seg_raw = 7'h00;
    endcase
  end

  assign w_onehot   = {{(DIGIT_NUM-1){1'b0}}, 1'b1} << r_idx;
  assign w_gate_nxt = (r_cnt < BLANK_CNT) ? '0 : w_onehot;
  assign w_seg_nxt  = {w_dp, w_seg_raw};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt        <= '0;
      r_idx        <= '0;
      r_dp         <= '0;
      r_mode_req   <= 1'b0;
      r_mode       <= 1'b0;
      r_shadow     <= '0;
      r_frame_done <= 1'b0;
      r_seg        <= ACTIVE_LOW ? 8'hFF : 8'h00;
      r_gate       <= ACTIVE_LOW ? '1 : '0;
      for (int i = 0; i < DIGIT_NUM; i++) r_user_digit[i] <= 4'h0;
    end else begin
      r_cnt <= w_cnt_wrap ? 28'd0 : r_cnt + 28'd1;
      if (w_cnt_wrap) r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;

      if (w_digit_wr) begin
        r_user_digit[w_off[IDXW-1:0]] <= wrData[3:0];
        r_dp[w_off[IDXW-1:0]]         <= wrData[4];
      end
      r_mode_req <= w_mode_req_nxt;

      if (w_boundary) begin
        r_mode   <= w_mode_req_nxt;
        r_shadow <= {cycleCount[HALF_W-1:0], sortCount[HALF_W-1:0]};
      end
      r_frame_done <= w_boundary;

      r_gate <= ACTIVE_LOW ? ~w_gate_nxt : w_gate_nxt;
      r_seg  <= ACTIVE_LOW ? ~w_seg_nxt : w_seg_nxt;
    end
  end

  assign segOut    = r_seg;
  assign gateOut   = r_gate;
  assign ledMode   = r_mode;
  assign frameDone = r_frame_done;

endmodule

// File: doc/led_scan_ctrl.md
Name: led_scan_ctrl

Overview:
- Parametrised memory-mapped multi-digit 7-segment scan controller on the CPU IO bus.
- Replaces fixed 8-digit LED output with configurable digit count, scan rate, blanking and output polarity.
- Mode register selects one of two sources for the display:
  - user-written hex digits (LED_CTRL_USER);
  - a frame-synchronised snapshot of sort count and cycle count (LED_CTRL_SORT_RESULT).

Parameters:
- DIGIT_NUM, 8, number of digits. Must be even, 2..16.
- SCAN_COUNT, 28'h3000, clk cycles per digit period. Must be ≥ 2.
- BLANK_CYCLES, 16, cycles at the start of each digit period with all gates off. Must be < SCAN_COUNT.
- ACTIVE_LOW, 1, when 1 segOut and gateOut are inverted at the output register.
- LED_BASE_ADDR, 5'h8, IO address of digit 0. Digit i is at LED_BASE_ADDR+i.
- LED_CTRL_ADDR, 5'h3, IO address of the mode register.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- wrEnable  in  1  IO write strobe
- wrAddr  in  5  IO word address, as produced by PICK_IO_ADDR
- wrData  in  16  IO write data
- sortCount  in  32  sort count
- cycleCount  in  32  current cycle count
- segOut  out  8  segments; bit0=a … bit6=g, bit7=dp
- gateOut  out  DIGIT_NUM  digit enables, one-hot when active
- ledMode  out  1  currently applied mode
- frameDone  out  1  one-cycle pulse at frame boundary

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high (rst); it is sampled only on the rising edge of clk.
- Reset state:
  - prescaler cnt=0, digit index idx=0;
  - user digits=0, dp bits=0;
  - mode request=0, applied mode=0;
  - shadow=0, frameDone=0;
  - segOut and gateOut at inactive level: all 1 if ACTIVE_LOW, else all 0.
- Reset mid-operation returns to the reset state on the next edge. No partial frame completes.
- Writes, effective the next cycle:
  - addr==LED_BASE_ADDR+i with i<DIGIT_NUM: userDigit[i]←wrData[3:0], dp[i]←wrData[4].
  - addr==LED_CTRL_ADDR: modeReq←wrData[0].
  - Any other address, or i≥DIGIT_NUM: ignored, no side effect.
- Prescaler:
  - cnt increments every cycle and wraps SCAN_COUNT-1→0.
  - On the wrap, idx←(idx+1) mod DIGIT_NUM.
- Frame boundary = cnt==SCAN_COUNT-1 and idx==DIGIT_NUM-1. On that edge:
  - applied mode←modeReq;
  - shadow←{cycleCount[(DIGIT_NUM/2)*4-1:0], sortCount[(DIGIT_NUM/2)*4-1:0]};
  - frameDone=1 for exactly the following cycle.
- Source digit for idx:
  - mode 1: userDigit[idx], dp[idx].
  - mode 0: shadow[idx*4+:4], dp=0. The low half of the digits shows sortCount nibbles, the high half shows cycleCount nibbles.
- Hex decode, 0..F → 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71. dp goes on bit7.
- Output register, one cycle latency from cnt/idx/source:
  - gate is inactive when cnt<BLANK_CYCLES, else one-hot bit idx;
  - seg is the decoded pattern;
  - both are inverted when ACTIVE_LOW=1.
- ledMode reflects the applied mode, not modeReq.
- Simultaneous events:
  - A write to the user digit currently displayed is visible on segOut 2 cycles after the write cycle.
  - A mode write in the frame-boundary cycle is applied at that boundary, because the write and the apply land on the same edge.
- Widths: DIGIT_NUM/2*4 ≤ 32, so at most 8 nibbles per source. Counter width is 28 bits.

Test Plan:
- Reset release, DIGIT_NUM=8, SCAN_COUNT=4, BLANK_CYCLES=1, ACTIVE_LOW=1:
  - all outputs inactive during reset;
  - frame 0 shows gate 0xFE pattern over digit 0 with segOut=~0x3F (digit zero);
  - gate inactive during each blank cycle.
- Mode 1; write digits 0..7 = 0..7 with dp on digit 3 (wrData=0x13); wait for the boundary:
  - segOut equals ~decode(i) while gate i is active;
  - digit 3 segOut=~0xCF.
- Mode 0; sortCount=0x1234, cycleCount=0xABCD at the boundary, then change both mid-frame:
  - digits 0..7 show 4,3,2,1,D,C,B,A through the whole next frame;
  - new values appear only after the following boundary.
- Write LED_CTRL_ADDR=1 mid-frame:
  - ledMode stays 0 until the boundary, then 1;
  - frameDone pulses exactly one cycle per 32 clk.
- Write to addr 5'h1F and to LED_BASE_ADDR+8 (DIGIT_NUM=8): no register changes.
- Assert rst for 1 cycle at idx=5, cnt=2: next cycle cnt=0, idx=0, and all registers are at reset values.
